// File: rtl/spi_ram_master_if.sv
// Host command/response bundle for spi_ram_master.
// The master side issues commands; the slave side executes them.
interface spi_ram_master_if #(
  parameter int ADDR_SIZE = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [1:0]           cmd_op;
  logic [ADDR_SIZE-1:0] cmd_data;
  logic                 rsp_valid;
  logic [ADDR_SIZE-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/spi_ram_master.sv
// SPI master for the slave+RAM subsystem.
// One bit per clk; frames {op, payload}, read data on MISO.
module spi_ram_master #(
  parameter int MEM_DEPTH = 256,
  parameter int RD_GAP    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  spi_ram_master_if.slave bus,
  output logic            busy,
  output logic            SS_n,
  output logic            MOSI,
  input  logic            MISO
);
  localparam int ADDR_SIZE = $clog2(MEM_DEPTH);
  localparam int FRAME_W   = ADDR_SIZE + 2;
  localparam int CNT_W     = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    IDLE, SEL, SHIFT, GAP, RECV, DONE
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [FRAME_W-1:0]   sh_q, sh_d;
  logic [ADDR_SIZE-1:0] rx_q, rx_d;
  logic                 rd_q, rd_d;
  logic                 ss_n_q, ss_n_d;
  logic                 mosi_q, mosi_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 rv_q, rv_d;
  logic [ADDR_SIZE-1:0] rdata_q, rdata_d;
  logic [ADDR_SIZE-1:0] pay;

  // Next state plus registered-output values derived from it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rd_d    = rd_q;
    rv_d    = 1'b0;
    rdata_d = rdata_q;
    pay     = (bus.cmd_op == 2'b11) ?
              {ADDR_SIZE{1'b0}} : bus.cmd_data;
    unique case (state_q)
      IDLE: begin
        if (bus.cmd_valid && ready_q) begin
          sh_d    = {bus.cmd_op, pay};
          rd_d    = (bus.cmd_op == 2'b11);
          state_d = SEL;
          cnt_d   = CNT_W'(1);
        end
      end
      SEL: begin
        if (cnt_q == CNT_W'(2)) begin
          state_d = SHIFT;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_W'(FRAME_W)) begin
          state_d = rd_q ? GAP : DONE;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          sh_d  = {sh_q[FRAME_W-2:0], 1'b0};
        end
      end
      GAP: begin
        if (cnt_q == CNT_W'(RD_GAP)) begin
          state_d = RECV;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RECV: begin
        rx_d = {rx_q[ADDR_SIZE-2:0], MISO};
        if (cnt_q == CNT_W'(ADDR_SIZE)) begin
          state_d = DONE;
          rv_d    = 1'b1;
          rdata_d = rx_d;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ss_n_d  = (state_d == IDLE) ||
              (state_d == DONE);
    busy_d  = (state_d != IDLE);
    ready_d = (state_d == IDLE);
    mosi_d  = 1'b0;
    if ((state_d == SEL && cnt_d == CNT_W'(2)) ||
        state_d == SHIFT)
      mosi_d = sh_d[FRAME_W-1];
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      rd_q    <= 1'b0;
      ss_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      rv_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rd_q    <= rd_d;
      ss_n_q  <= ss_n_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      rv_q    <= rv_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_data  = rdata_q;
  assign busy          = busy_q;
  assign SS_n          = ss_n_q;
  assign MOSI          = mosi_q;
endmodule
